// File: rtl/wb_host_master_pkg.sv
// Shared types and constants for the Wishbone host master.
// State encoding, error data pattern and watchdog counter sizing.
package wb_host_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_DEF + 1);

    function automatic int unsigned cnt_width(input int unsigned t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/wb_host_master_if.sv
// Command/response streams plus Wishbone master bus of wb_host_master.
// master = the host master itself, slave = whoever drives it and the bus.
interface wb_host_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_W-1:0]     req_adr_i;
    logic [DATA_W-1:0]     req_dat_i;
    logic [DATA_W/8-1:0]   req_sel_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_dat_o;
    logic                  rsp_err_o;

    logic                  wbm_cyc_o;
    logic                  wbm_stb_o;
    logic                  wbm_we_o;
    logic [DATA_W/8-1:0]   wbm_sel_o;
    logic [ADDR_W-1:0]     wbm_adr_o;
    logic [DATA_W-1:0]     wbm_dat_o;
    logic                  wbm_ack_i;
    logic [DATA_W-1:0]     wbm_dat_i;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output req_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        output wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        input  wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/wb_host_master_watchdog.sv
// Ack watchdog: counts unacknowledged bus cycles, flags expiry.
// Instantiated only when WB_HOST_MASTER_TIMEOUT_EN is defined.
module wb_host_watchdog
    import wb_host_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CW      = CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the TIMEOUT-th unacknowledged cycle so the bus drops after it.
    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready stream.
// Optional ack watchdog enabled by defining WB_HOST_MASTER_TIMEOUT_EN.
module wb_host_master
    import wb_host_master_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_host_master_if.master  bus
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     adr_q, adr_d;
    logic [DATA_W-1:0]     dat_q, dat_d;
    logic [DATA_W/8-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]     rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  expire;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    wb_host_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CW      (cnt_width(TIMEOUT))
    ) u_wdog (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clr_i    (state_q != BUS),
        .en_i     ((state_q == BUS) && !bus.wbm_ack_i),
        .expire_o (expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    state_d = BUS;
                    we_d    = bus.req_we_i;
                    adr_d   = bus.req_adr_i;
                    dat_d   = bus.req_dat_i;
                    sel_d   = bus.req_sel_i;
                end
            end
            BUS: begin
                // Ack has priority over a simultaneous watchdog expiry.
                if (bus.wbm_ack_i) begin
                    state_d   = RESP;
                    rsp_dat_d = we_q ? '0 : bus.wbm_dat_i;
                    rsp_err_d = 1'b0;
                end else if (expire) begin
                    state_d   = RESP;
                    rsp_dat_d = DATA_W'(ERR_DATA);
                    rsp_err_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.wbm_cyc_o   = (state_q == BUS);
    assign bus.wbm_stb_o   = (state_q == BUS);
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;
    assign bus.wbm_sel_o   = sel_q;

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic single-transfer initiator: the master end of the same 32-bit Wishbone bus the user project exposes as a slave. It turns a valid/ready command stream into one Wishbone cycle per command and returns the read data or write completion on a valid/ready response stream. It lets the team's user logic and testbenches drive Wishbone slaves, including the user-area slave port, from local logic. An optional watchdog aborts a transfer when the slave never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte select width is DATA_W/8
- TIMEOUT, 255, bus cycles to wait for ack before abort; must be 1..65535; used only with the watchdog
- wb_clk_i  in  1  sole clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  command present
- req_ready_o  out  1  command accepted when high with req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  ADDR_W  byte address, passed through unmodified
- req_dat_i  in  DATA_W  write data
- req_sel_i  in  DATA_W/8  byte selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o
- rsp_dat_o  out  DATA_W  read data; 0 for writes
- rsp_err_o  out  1  transfer aborted by the watchdog
- wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone cycle and strobe, always equal
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  DATA_W/8  byte selects
- wbm_adr_o  out  ADDR_W  address
- wbm_dat_o  out  DATA_W  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  DATA_W  slave read data

## Operation
- FSM states:
  - IDLE -> BUS on req_valid_i & req_ready_o.
  - BUS -> RESP on wbm_ack_i, or on watchdog expiry.
  - RESP -> IDLE on rsp_valid_o & rsp_ready_i.
- Outputs by state:
  - req_ready_o = 1 only in IDLE.
  - rsp_valid_o = 1 only in RESP.
  - wbm_cyc_o = wbm_stb_o = 1 only in BUS.
- On acceptance, register we/adr/dat/sel. The wbm_* outputs are driven from these registers and stay stable through BUS.
- On ack during a read, capture wbm_dat_i into rsp_dat_o. On ack during a write, rsp_dat_o = 0. In both cases rsp_err_o = 0.
- rsp_dat_o and rsp_err_o hold while in RESP, even if rsp_ready_i is low.
- wbm_ack_i outside BUS is ignored.
- Reset: state IDLE; all outputs 0 except req_ready_o = 1 (it becomes 1 in the first cycle after reset releases). A reset asserted during BUS drops cyc/stb at that edge and discards the transfer. A reset during RESP drops the response.

## Timing
- Command accepted at edge N: cyc/stb high from cycle N+1.
- Ack sampled high at edge M: cyc/stb low and rsp_valid_o high from cycle M+1.
- Minimum latency, with a slave that acks in the first strobe cycle: accept at N, ack at N+1, rsp_valid_o at N+2.
- Response handshake at edge K: req_ready_o high from cycle K+1. A new command is never accepted in the same cycle as a response handshake.
- Best-case throughput: one transfer per 3 cycles.
- Watchdog (only when compiled in):
  - Counter cleared on entry to BUS and incremented each BUS cycle without ack.
  - When it reaches TIMEOUT without ack, the next state is RESP with rsp_err_o = 1 and rsp_dat_o all-ones.
  - Ack in the same cycle as expiry: ack wins, rsp_err_o = 0.

## Configuration
- WB_HOST_MASTER_TIMEOUT_EN defined: watchdog counter present, behaving as in Timing.
- WB_HOST_MASTER_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for ack; rsp_err_o tied to 0; TIMEOUT unused.

## Structure
- Package wb_host_master_pkg holds:
  - state enum (IDLE, BUS, RESP);
  - constant ERR_DATA (all-ones) for the error read data;
  - localparam for counter width, $clog2(TIMEOUT+1).
- One sub-module, wb_host_watchdog: counter with clear, enable and expire outputs. It is instantiated only under WB_HOST_MASTER_TIMEOUT_EN.

## Test plan
- Read, slave acks one cycle after stb with dat 0xA5A5_1234:
  - command at N gives cyc/stb at N+1 and rsp_valid_o at N+3;
  - rsp_dat_o = 0xA5A5_1234, rsp_err_o = 0.
- Write adr 0x3000_0004, dat 0xCAFE_F00D, sel 0x3; slave acks after 4 wait cycles:
  - wbm_* outputs stable for all 5 strobe cycles;
  - rsp_dat_o = 0, rsp_err_o = 0.
- Backpressure: rsp_ready_i held low for 6 cycles after a read:
  - rsp_valid_o and the data are held, req_ready_o stays 0;
  - when ready rises, req_ready_o goes high the next cycle.
- With WB_HOST_MASTER_TIMEOUT_EN and TIMEOUT = 8, slave never acks:
  - cyc drops after 8 strobe cycles;
  - rsp_err_o = 1, rsp_dat_o = 0xFFFF_FFFF.
  - Repeat with ack on exactly the 8th cycle: normal response, err = 0.
- Reset asserted in the second BUS cycle:
  - cyc/stb low after that edge, rsp_valid_o stays 0;
  - req_ready_o = 1 in the first cycle after reset releases;
  - a late ack is ignored.
- Back-to-back: 16 random read/write commands with random slave wait states (0-5) and random rsp_ready_i:
  - every command produces exactly one response, in order, with scoreboard-matched data.
